nibbler2: RTL and testbench

NIBBLER2 -- requirements
Module: nibbler2

---
 rtl/nibbler2.sv | 222 ++++++++++++++++++++++
 tb/tb_nibbler2.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/nibbler2.sv
// nibbler2: multi-cycle 4-opcode-bit accumulator core with a fetch handshake,
// internal data RAM, a small return stack and one input/output port.
module nibbler2 #(
  parameter int unsigned DATA_W      = 4,
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  output logic [ADDR_W-1:0]   imem_addr,
  output logic                imem_req,
  input  logic [DATA_W+3:0]   imem_data,
  input  logic                imem_valid,
  input  logic [DATA_W-1:0]   in_data,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_strobe,
  output logic [DATA_W-1:0]   acc,
  output logic                flag_c,
  output logic                flag_z,
  output logic [ADDR_W-1:0]   pc,
  output logic                halted,
  output logic                stack_err
);

  localparam int unsigned IW        = 4 + DATA_W;
  localparam int unsigned TGT_W     = DATA_W + IW;
  localparam int unsigned RAM_DEPTH = 1 << DATA_W;
  localparam int unsigned SP_W      = $clog2(STACK_DEPTH + 1);
  localparam int unsigned STK_SLOTS = 1 << SP_W;

  localparam logic [1:0] S_FETCH  = 2'd0;
  localparam logic [1:0] S_FETCH2 = 2'd1;
  localparam logic [1:0] S_EXEC   = 2'd2;
  localparam logic [1:0] S_HALT   = 2'd3;

  // Reject unsupported configurations at elaboration
  if (DATA_W < 4 || DATA_W > 16) begin : g_bad_data_w
    $error("nibbler2: DATA_W must be 4..16");
  end
  if (ADDR_W > TGT_W) begin : g_bad_addr_w
    $error("nibbler2: ADDR_W must not exceed 2*DATA_W+4");
  end
  if (STACK_DEPTH < 1 || STACK_DEPTH > 16) begin : g_bad_depth
    $error("nibbler2: STACK_DEPTH must be 1..16");
  end

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              flag_c_q, flag_c_d;
  logic              flag_z_q, flag_z_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_strobe_q, out_strobe_d;
  logic              halted_q, halted_d;
  logic              stack_err_q, stack_err_d;
  logic              imem_req_q, imem_req_d;
  logic [3:0]        op_q, op_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [IW-1:0]     lo_q, lo_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              ram_we, stk_we;

  logic [DATA_W-1:0] ram_q   [RAM_DEPTH];
  logic [ADDR_W-1:0] stack_q [STK_SLOTS];

  logic [3:0]        fetch_op;
  logic [DATA_W:0]   sum;
  logic [ADDR_W-1:0] target;
  logic [DATA_W-1:0] new_acc;

  assign fetch_op = imem_data[IW-1:DATA_W];
  assign sum      = {1'b0, acc_q} + {1'b0, imm_q};
  assign target   = ADDR_W'({imm_q, lo_q});

  // Next-state and datapath update
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    acc_d        = acc_q;
    flag_c_d     = flag_c_q;
    flag_z_d     = flag_z_q;
    out_data_d   = out_data_q;
    out_strobe_d = 1'b0;
    halted_d     = halted_q;
    stack_err_d  = stack_err_q;
    op_d         = op_q;
    imm_d        = imm_q;
    lo_d         = lo_q;
    sp_d         = sp_q;
    ram_we       = 1'b0;
    stk_we       = 1'b0;
    new_acc      = acc_q;

    case (state_q)
      S_FETCH: begin
        if (imem_valid) begin
          op_d    = fetch_op;
          imm_d   = imem_data[DATA_W-1:0];
          pc_d    = pc_q + ADDR_W'(1);
          state_d = (fetch_op >= 4'hA && fetch_op <= 4'hD) ? S_FETCH2 : S_EXEC;
        end
      end
      S_FETCH2: begin
        if (imem_valid) begin
          lo_d    = imem_data;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (op_q)
          4'h0: new_acc = imm_q;
          4'h1: begin
            new_acc  = sum[DATA_W-1:0];
            flag_c_d = sum[DATA_W];
          end
          4'h2: begin
            new_acc  = acc_q - imm_q;
            flag_c_d = (acc_q >= imm_q);
          end
          4'h3: new_acc = acc_q & imm_q;
          4'h4: new_acc = acc_q | imm_q;
          4'h5: new_acc = acc_q ^ imm_q;
          4'h6: new_acc = in_data;
          4'h7: begin
            out_data_d   = acc_q;
            out_strobe_d = 1'b1;
          end
          4'h8: new_acc = ram_q[imm_q];
          4'h9: ram_we = 1'b1;
          4'hA: pc_d = target;
          4'hB: if (flag_c_q) pc_d = target;
          4'hC: if (flag_z_q) pc_d = target;
          4'hD: begin
            if (sp_q == SP_W'(STACK_DEPTH)) begin
              stack_err_d = 1'b1;
            end else begin
              stk_we = 1'b1;
              sp_d   = sp_q + SP_W'(1);
              pc_d   = target;
            end
          end
          4'hE: begin
            if (sp_q == '0) begin
              stack_err_d = 1'b1;
            end else begin
              sp_d = sp_q - SP_W'(1);
              pc_d = stack_q[sp_q - SP_W'(1)];
            end
          end
          default: begin
            state_d  = S_HALT;
            halted_d = 1'b1;
          end
        endcase
        // Only data-producing opcodes touch the accumulator and zero flag
        if (op_q <= 4'h6 || op_q == 4'h8) begin
          acc_d    = new_acc;
          flag_z_d = (new_acc == '0);
        end
      end
      S_HALT: ;
      default: state_d = S_FETCH;
    endcase

    imem_req_d = (state_d == S_FETCH) || (state_d == S_FETCH2);
  end

  // Architectural state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_FETCH;
      pc_q         <= '0;
      acc_q        <= '0;
      flag_c_q     <= 1'b0;
      flag_z_q     <= 1'b0;
      out_data_q   <= '0;
      out_strobe_q <= 1'b0;
      halted_q     <= 1'b0;
      stack_err_q  <= 1'b0;
      imem_req_q   <= 1'b1;
      op_q         <= '0;
      imm_q        <= '0;
      lo_q         <= '0;
      sp_q         <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      acc_q        <= acc_d;
      flag_c_q     <= flag_c_d;
      flag_z_q     <= flag_z_d;
      out_data_q   <= out_data_d;
      out_strobe_q <= out_strobe_d;
      halted_q     <= halted_d;
      stack_err_q  <= stack_err_d;
      imem_req_q   <= imem_req_d;
      op_q         <= op_d;
      imm_q        <= imm_d;
      lo_q         <= lo_d;
      sp_q         <= sp_d;
    end
  end

  // Storage arrays are not reset; writes happen only on EXEC edges
  always_ff @(posedge clk) begin
    if (ram_we) ram_q[imm_q] <= acc_q;
    if (stk_we) stack_q[sp_q] <= pc_q;
  end

  assign imem_addr  = pc_q;
  assign imem_req   = imem_req_q;
  assign out_data   = out_data_q;
  assign out_strobe = out_strobe_q;
  assign acc        = acc_q;
  assign flag_c     = flag_c_q;
  assign flag_z     = flag_z_q;
  assign pc         = pc_q;
  assign halted     = halted_q;
  assign stack_err  = stack_err_q;

endmodule

// File: tb/tb_nibbler2.sv
// Directed scoreboard bench for nibbler2 with default parameters and a
// combinational program ROM.
module tb_nibbler2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] imem_addr;
  logic        imem_req;
  logic [7:0]  imem_data;
  logic        imem_valid = 1'b1;
  logic [3:0]  in_data = 4'h0;
  logic [3:0]  out_data;
  logic        out_strobe;
  logic [3:0]  acc;
  logic        flag_c, flag_z;
  logic [11:0] pc;
  logic        halted, stack_err;

  logic [7:0]  prog [4096];

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  int tests = 0;
  int fails = 0;

  nibbler2 dut (
    .clk(clk), .reset(reset),
    .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_data(imem_data), .imem_valid(imem_valid),
    .in_data(in_data), .out_data(out_data), .out_strobe(out_strobe),
    .acc(acc), .flag_c(flag_c), .flag_z(flag_z),
    .pc(pc), .halted(halted), .stack_err(stack_err)
  );

  always #5 clk = ~clk;
  assign imem_data = prog[imem_addr];

  task automatic clear_prog();
    for (int i = 0; i < 4096; i++) prog[i] = 8'hF0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic exp_push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $error("FAIL scoreboard_empty observed=%0h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        fails++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  initial begin
    // Reset values and LIT/ADD/SUB flags and timing
    clear_prog();
    prog[0] = 8'h09; prog[1] = 8'h19; prog[2] = 8'h22;
    hold_reset();
    exp_push("rst_pc", 0);        exp_push("rst_acc", 0);
    exp_push("rst_flags", 0);     exp_push("rst_out", 0);
    exp_push("rst_halted", 0);    exp_push("rst_err", 0);
    exp_push("rst_req", 1);
    check(32'(pc)); check(32'(acc)); check(32'({flag_c, flag_z}));
    check(32'({out_data, out_strobe})); check(32'(halted));
    check(32'(stack_err)); check(32'(imem_req));
    reset = 1'b1;
    exp_push("add_acc", 2); exp_push("add_flags", 2'b10); exp_push("add_pc", 2);
    step(4);
    check(32'(acc)); check(32'({flag_c, flag_z})); check(32'(pc));
    exp_push("sub_acc", 0); exp_push("sub_flags", 2'b11);
    step(2);
    check(32'(acc)); check(32'({flag_c, flag_z}));

    // JZ taken
    clear_prog();
    prog[0] = 8'h00; prog[1] = 8'hC1; prog[2] = 8'h23;
    hold_reset(); reset = 1'b1;
    step(2);
    exp_push("jz_taken_pc", 12'h123);
    step(3);
    check(32'(pc));

    // JZ not taken
    prog[0] = 8'h01;
    hold_reset(); reset = 1'b1;
    exp_push("jz_fall_pc", 3); exp_push("jz_fall_z", 0);
    step(5);
    check(32'(pc)); check(32'(flag_z));

    // Logic ops, IN, ST/LD, JC, SUB with borrow
    clear_prog();
    prog[0] = 8'h0C; prog[1] = 8'h3A; prog[2] = 8'h41; prog[3] = 8'h59;
    prog[4] = 8'h60; prog[5] = 8'h93; prog[6] = 8'h00; prog[7] = 8'h83;
    prog[8] = 8'h1F; prog[9] = 8'hB0; prog[10] = 8'h40;
    prog[12'h040] = 8'h01; prog[12'h041] = 8'h22;
    in_data = 4'hA;
    hold_reset(); reset = 1'b1;
    exp_push("and_or_acc", 9);
    step(6); check(32'(acc));
    exp_push("xor_acc", 0); exp_push("xor_flags", 2'b01);
    step(2); check(32'(acc)); check(32'({flag_c, flag_z}));
    exp_push("in_acc", 4'hA); exp_push("in_z", 0);
    step(2); check(32'(acc)); check(32'(flag_z));
    exp_push("ld_acc", 4'hA);
    step(6); check(32'(acc));
    exp_push("add_wrap_acc", 9); exp_push("add_wrap_c", 1);
    step(2); check(32'(acc)); check(32'(flag_c));
    exp_push("jc_pc", 12'h040);
    step(3); check(32'(pc));
    exp_push("sub_borrow_acc", 4'hF); exp_push("sub_borrow_flags", 2'b00);
    step(4); check(32'(acc)); check(32'({flag_c, flag_z}));

    // Nested CALL overflow and RET underflow
    clear_prog();
    prog[12'h000] = 8'hD0; prog[12'h001] = 8'h10;
    prog[12'h010] = 8'hD0; prog[12'h011] = 8'h20;
    prog[12'h020] = 8'hD0; prog[12'h021] = 8'h30;
    prog[12'h030] = 8'hD0; prog[12'h031] = 8'h40;
    prog[12'h040] = 8'hD0; prog[12'h041] = 8'h50;
    prog[12'h042] = 8'hE0; prog[12'h032] = 8'hE0; prog[12'h022] = 8'hE0;
    prog[12'h012] = 8'hE0; prog[12'h002] = 8'hE0; prog[12'h003] = 8'hF0;
    hold_reset(); reset = 1'b1;
    exp_push("call4_pc", 12'h040); exp_push("call4_err", 0);
    step(12); check(32'(pc)); check(32'(stack_err));
    exp_push("call5_pc", 12'h042); exp_push("call5_err", 1);
    step(3); check(32'(pc)); check(32'(stack_err));
    exp_push("ret1_pc", 12'h032); step(2); check(32'(pc));
    exp_push("ret2_pc", 12'h022); step(2); check(32'(pc));
    exp_push("ret3_pc", 12'h012); step(2); check(32'(pc));
    exp_push("ret4_pc", 12'h002); step(2); check(32'(pc));
    exp_push("ret5_pc", 12'h003); exp_push("ret5_err", 1);
    step(2); check(32'(pc)); check(32'(stack_err));
    exp_push("halt_flag", 1); exp_push("halt_req", 0);
    step(2); check(32'(halted)); check(32'(imem_req));
    exp_push("halt_hold_pc", 12'h004); exp_push("halt_hold", 2'b10);
    step(3); check(32'(pc)); check(32'({halted, imem_req}));

    // imem_valid low stalls FETCH
    clear_prog();
    prog[0] = 8'h09;
    hold_reset(); reset = 1'b1;
    imem_valid = 1'b0;
    exp_push("stall_pc", 0); exp_push("stall_acc", 0); exp_push("stall_req", 1);
    step(3); check(32'(pc)); check(32'(acc)); check(32'(imem_req));
    imem_valid = 1'b1;
    exp_push("stall_mid_acc", 0);
    step(1); check(32'(acc));
    exp_push("stall_done_acc", 9); exp_push("stall_done_pc", 1);
    step(1); check(32'(acc)); check(32'(pc));

    // PC wrap at 0xFFF
    clear_prog();
    prog[0] = 8'hAF; prog[1] = 8'hFF; prog[12'hFFF] = 8'h05;
    hold_reset(); reset = 1'b1;
    exp_push("wrap_jmp_pc", 12'hFFF); step(3); check(32'(pc));
    exp_push("wrap_acc", 5); exp_push("wrap_addr", 0);
    step(2); check(32'(acc)); check(32'(imem_addr));

    // OUT strobe
    clear_prog();
    prog[0] = 8'h05; prog[1] = 8'h70;
    hold_reset(); reset = 1'b1;
    exp_push("out_pre_strobe", 0); step(3); check(32'(out_strobe));
    exp_push("out_data", 5); exp_push("out_strobe", 1);
    step(1); check(32'(out_data)); check(32'(out_strobe));
    exp_push("out_hold", 5); exp_push("out_strobe_end", 0);
    step(1); check(32'(out_data)); check(32'(out_strobe));

    // Reset during FETCH2 of a CALL
    clear_prog();
    prog[12'h000] = 8'hD0; prog[12'h001] = 8'h10;
    prog[12'h010] = 8'hD0; prog[12'h011] = 8'h20;
    hold_reset(); reset = 1'b1;
    exp_push("call_mid_pc", 12'h010); step(3); check(32'(pc));
    step(1);
    reset = 1'b0;
    #1;
    exp_push("midrst_pc", 0); exp_push("midrst_err", 0); exp_push("midrst_req", 1);
    check(32'(pc)); check(32'(stack_err)); check(32'(imem_req));
    prog[0] = 8'hE0; prog[1] = 8'hF0;
    step(1);
    reset = 1'b1;
    exp_push("empty_ret_err", 1); exp_push("empty_ret_pc", 1);
    step(2); check(32'(stack_err)); check(32'(pc));
    exp_push("final_halt", 2'b10);
    step(5); check(32'({halted, imem_req}));

    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
